// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder_if
//  Purpose  : Request/result handshake bundle for the immediate encoder.
//             master : request producer / result consumer side
//             slave  : the encoder itself
//  Signals  : in_valid/in_ready/in_itype/in_tmpl/in_imm   request channel
//             out_valid/out_ready/out_inst/out_err        result channel
//  Revision : 1.0  initial release
// ============================================================================
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_itype;
    logic [31:0] in_tmpl;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;

    modport master (
        output in_valid, in_itype, in_tmpl, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_err
    );

    modport slave (
        input  in_valid, in_itype, in_tmpl, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_err
    );
endinterface
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder
//  Purpose  : Packs a 32-bit immediate into the immediate fields of a RISC-V
//             instruction template (I/S/B/U/J and I-type shift form), flags
//             unrepresentable immediates and counts delivered errors.
//             Two-stage valid/ready pipeline: stage 1 registers the request
//             and its error flag, stage 2 registers the packed instruction.
//  Ports    : clk      rising-edge clock
//             rst_n    asynchronous active-low reset
//             bus      imm_encoder_if.slave request/result handshake
//             err_clr  synchronous clear of err_cnt (wins over increment)
//             err_cnt  saturating count of results delivered with out_err=1
//  Revision : 1.0  initial release
// ============================================================================
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    imm_encoder_if.slave          bus,
    input  wire logic             err_clr,
    output logic [CNT_W-1:0]      err_cnt
);

    // Shared format codes; 6 and 7 are undefined.
    localparam logic [2:0] c_i_type    = 3'd0;
    localparam logic [2:0] c_s_type    = 3'd1;
    localparam logic [2:0] c_b_type    = 3'd2;
    localparam logic [2:0] c_u_type    = 3'd3;
    localparam logic [2:0] c_j_type    = 3'd4;
    localparam logic [2:0] c_null_type = 3'd5;

    localparam logic [6:0] c_op_imm    = 7'b0010011;

    // ---------------- flow control ----------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q  || s2_adv;

    // ---------------- stage 1: classify and check ----------------
    logic        shift_d;
    logic        err_d;
    logic [31:0] imm;

    assign imm = bus.in_imm;

    // funct3 001 (slli) and 101 (srli/srai) share bits [13:12] = 01, bit 14 free.
    assign shift_d = (bus.in_itype == c_i_type) &&
                     (bus.in_tmpl[6:0] == c_op_imm) &&
                     (bus.in_tmpl[13:12] == 2'b01);

    always_comb begin
        err_d = 1'b1;
        case (bus.in_itype)
            c_i_type:    err_d = shift_d ? (|imm[31:5])
                                         : !((&imm[31:11]) || !(|imm[31:11]));
            c_s_type:    err_d = !((&imm[31:11]) || !(|imm[31:11]));
            c_b_type:    err_d = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            c_u_type:    err_d = |imm[11:0];
            c_j_type:    err_d = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            c_null_type: err_d = 1'b0;
            default:     err_d = 1'b1;
        endcase
    end

    logic [2:0]  s1_itype_q;
    logic [31:0] s1_tmpl_q;
    logic [31:0] s1_imm_q;
    logic        s1_shift_q;
    logic        s1_err_q;

    // ---------------- stage 2: field packing ----------------
    logic [31:0] inst_d;
    logic [31:0] t;
    logic [31:0] m;

    assign t = s1_tmpl_q;
    assign m = s1_imm_q;

    always_comb begin
        inst_d = t;
        case (s1_itype_q)
            c_i_type: inst_d = s1_shift_q ? {t[31:25], m[4:0], t[19:0]}
                                          : {m[11:0], t[19:0]};
            c_s_type: inst_d = {m[11:5], t[24:12], m[4:0], t[6:0]};
            c_b_type: inst_d = {m[12], m[10:5], t[24:12], m[4:1], m[11], t[6:0]};
            c_u_type: inst_d = {m[31:12], t[11:0]};
            c_j_type: inst_d = {m[20], m[10:1], m[11], m[19:12], t[11:0]};
            default:  inst_d = t;   // NULL and undefined codes pass the template
        endcase
    end

    logic [31:0]      out_inst_q;
    logic             out_err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Count only results actually handed over with the error flag set.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && out_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_itype_q  <= 3'd0;
            s1_tmpl_q   <= 32'd0;
            s1_imm_q    <= 32'd0;
            s1_shift_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_itype_q <= bus.in_itype;
                    s1_tmpl_q  <= bus.in_tmpl;
                    s1_imm_q   <= bus.in_imm;
                    s1_shift_q <= shift_d;
                    s1_err_q   <= err_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_inst_q <= inst_d;
                    out_err_q  <= s1_err_q;
                end
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder
//  Purpose  : Directed self-checking bench for imm_encoder. A second instance
//             with a 2-bit counter mirrors the same stimulus to exercise
//             counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

    localparam logic [2:0] I_T = 3'd0;
    localparam logic [2:0] S_T = 3'd1;
    localparam logic [2:0] B_T = 3'd2;
    localparam logic [2:0] U_T = 3'd3;
    localparam logic [2:0] J_T = 3'd4;
    localparam logic [2:0] N_T = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clr;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;

    logic [31:0] q_inst[$];
    logic        q_err[$];

    imm_encoder_if u_if ();
    imm_encoder_if u_if2 ();

    imm_encoder #(.CNT_W(16)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (u_if.slave),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    imm_encoder #(.CNT_W(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (u_if2.slave),
        .err_clr (err_clr),
        .err_cnt (err_cnt2)
    );

    assign u_if2.in_valid  = u_if.in_valid;
    assign u_if2.in_itype  = u_if.in_itype;
    assign u_if2.in_tmpl   = u_if.in_tmpl;
    assign u_if2.in_imm    = u_if.in_imm;
    assign u_if2.out_ready = u_if.out_ready;

    always #5 clk = ~clk;

    // Inputs change only on the falling edge; record handshakes that the
    // next rising edge will perform.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (u_if.in_valid && u_if.in_ready) n_acc++;
            if (u_if.out_valid && u_if.out_ready) begin
                q_inst.push_back(u_if.out_inst);
                q_err.push_back(u_if.out_err);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [2:0] it, input logic [31:0] tm, input logic [31:0] im);
        bit ok;
        ok = 1'b0;
        u_if.in_valid = 1'b1;
        u_if.in_itype = it;
        u_if.in_tmpl  = tm;
        u_if.in_imm   = im;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (u_if.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 200 && q_inst.size() < n; k++) @(negedge clk);
        if (q_inst.size() < n) check("drain_timeout", q_inst.size(), n);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] inst, input logic err);
        logic [31:0] gi;
        logic        ge;
        if (q_inst.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            gi = q_inst.pop_front();
            ge = q_err.pop_front();
            check({tag, "_inst"}, gi, inst);
            check({tag, "_err"}, {31'd0, ge}, {31'd0, err});
        end
    endtask

    typedef struct packed {
        logic [2:0]  it;
        logic [31:0] tm;
        logic [31:0] im;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        err_clr       = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_itype = 3'd0;
        u_if.in_tmpl  = 32'd0;
        u_if.in_imm   = 32'd0;
        u_if.out_ready = 1'b1;

        // ---------------- reset state ----------------
        #2;
        check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("rst_out_inst", u_if.out_inst, 32'd0);
        check("rst_out_err", {31'd0, u_if.out_err}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);

        // ---------------- latency: addi -1 ----------------
        @(negedge clk);
        u_if.in_valid = 1'b1;
        u_if.in_itype = I_T;
        u_if.in_tmpl  = 32'h0001_0093;
        u_if.in_imm   = 32'hFFFF_FFFF;
        #1;
        check("lat_in_ready", {31'd0, u_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        check("lat_valid_n1", {31'd0, u_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid_n2", {31'd0, u_if.out_valid}, 32'd1);
        check("lat_inst", u_if.out_inst, 32'hFFF1_0093);
        wait_out(1);
        expect_out("addi_m1", 32'hFFF1_0093, 1'b0);

        // ---------------- back-to-back directed vectors ----------------
        vq.push_back({B_T, 32'h0000_0063, 32'hFFFF_FFFE, 32'hFE00_0FE3, 1'b0});
        vq.push_back({B_T, 32'h0000_0063, 32'h0000_1000, 32'h8000_0063, 1'b1});
        vq.push_back({I_T, 32'h4001_5093, 32'h0000_0003, 32'h4031_5093, 1'b0});
        vq.push_back({I_T, 32'h4001_5093, 32'h0000_0020, 32'h4001_5093, 1'b1});
        vq.push_back({U_T, 32'h0000_00B7, 32'h1234_5000, 32'h1234_50B7, 1'b0});
        vq.push_back({J_T, 32'h0000_006F, 32'h0000_0003, 32'h0020_006F, 1'b1});
        vq.push_back({J_T, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0});
        vq.push_back({S_T, 32'h0000_0023, 32'hFFFF_FFFC, 32'hFE00_0E23, 1'b0});
        vq.push_back({N_T, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0});
        vq.push_back({3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1});
        vq.push_back({I_T, 32'h0001_0093, 32'h0000_0800, 32'h8001_0093, 1'b1});
        vq.push_back({U_T, 32'h0000_00B7, 32'h0000_0001, 32'h0000_00B7, 1'b1});
        vq.push_back({I_T, 32'hABC1_0093, 32'h0000_0005, 32'h0051_0093, 1'b0});

        foreach (vq[i]) send(vq[i].it, vq[i].tm, vq[i].im);
        u_if.in_valid = 1'b0;
        wait_out(vq.size());
        foreach (vq[i]) expect_out($sformatf("vec%0d", i), vq[i].inst, vq[i].err);
        @(negedge clk);
        check("cnt_after_vec", {16'd0, err_cnt}, 32'd6);
        check("cnt2_saturated", {30'd0, err_cnt2}, 32'd3);

        // ---------------- backpressure ----------------
        u_if.out_ready = 1'b0;
        begin
            int a0;
            a0 = n_acc;
            fork
                begin
                    send(I_T, 32'h0001_0093, 32'd1);
                    send(I_T, 32'h0001_0093, 32'd2);
                    send(I_T, 32'h0001_0093, 32'd3);
                    u_if.in_valid = 1'b0;
                end
                begin
                    repeat (4) @(posedge clk);
                    #1;
                    check("bp_accepted", n_acc - a0, 32'd2);
                    check("bp_in_ready", {31'd0, u_if.in_ready}, 32'd0);
                    check("bp_out_valid", {31'd0, u_if.out_valid}, 32'd1);
                    check("bp_no_deliver", q_inst.size(), 32'd0);
                    @(negedge clk);
                    u_if.out_ready = 1'b1;
                end
            join
        end
        wait_out(3);
        expect_out("bp_a", 32'h0011_0093, 1'b0);
        expect_out("bp_b", 32'h0021_0093, 1'b0);
        expect_out("bp_c", 32'h0031_0093, 1'b0);
        repeat (5) @(negedge clk);
        check("bp_no_dup", q_inst.size(), 32'd0);

        // ---------------- err_clr coincident with error delivery ----------------
        u_if.out_ready = 1'b0;
        send(3'd7, 32'h1111_1111, 32'd0);
        u_if.in_valid = 1'b0;
        for (int k = 0; k < 20 && !u_if.out_valid; k++) @(negedge clk);
        check("clr_pending_valid", {31'd0, u_if.out_valid}, 32'd1);
        @(negedge clk);
        err_clr        = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("clr_wins", {16'd0, err_cnt}, 32'd0);
        check("clr_wins2", {30'd0, err_cnt2}, 32'd0);
        @(negedge clk);
        err_clr = 1'b0;
        expect_out("undef7", 32'h1111_1111, 1'b1);

        // ---------------- five errors: wide counts, narrow saturates ----------------
        for (int i = 0; i < 5; i++) send(U_T, 32'h0000_0037, 32'(i + 1));
        u_if.in_valid = 1'b0;
        wait_out(5);
        for (int i = 0; i < 5; i++) expect_out($sformatf("sat%0d", i), 32'h0000_0037, 1'b1);
        @(negedge clk);
        check("cnt_five", {16'd0, err_cnt}, 32'd5);
        check("cnt2_sat_five", {30'd0, err_cnt2}, 32'd3);

        // ---------------- asynchronous reset mid-stream ----------------
        u_if.out_ready = 1'b0;
        send(I_T, 32'h0001_0093, 32'h0000_0800);
        send(I_T, 32'h0001_0093, 32'h0000_0007);
        u_if.in_valid = 1'b0;
        #1;
        check("pre_rst_valid", {31'd0, u_if.out_valid}, 32'd1);
        check("pre_rst_err", {31'd0, u_if.out_err}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
        check("arst_out_inst", u_if.out_inst, 32'd0);
        check("arst_out_err", {31'd0, u_if.out_err}, 32'd0);
        check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
        #4;
        rst_n = 1'b1;
        q_inst.delete();
        q_err.delete();
        @(negedge clk);
        u_if.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_stale", q_inst.size(), 32'd0);
        check("post_rst_valid", {31'd0, u_if.out_valid}, 32'd0);
        send(U_T, 32'h0000_00B7, 32'h1234_5000);
        u_if.in_valid = 1'b0;
        wait_out(1);
        expect_out("post_rst_lui", 32'h1234_50B7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
# imm_encoder

Inverse of the immediate generator: packs a 32-bit immediate into the immediate fields of a RISC-V instruction template and emits the encoded instruction. Used by the NPC instruction-emit path (trap/stub generation and self-check stimulus) to build I/S/B/U/J instructions from the shared type codes. It is a 2-stage valid/ready pipeline with representability checking and a saturating error counter.

## Interface
- CNT_W, 16, width of the error counter

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_itype  input  3  format code from the shared type macros (I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, NULL_TYPE)
- in_tmpl  input  32  instruction template: opcode, funct, register fields; bits at immediate positions ignored
- in_imm  input  32  immediate value, two's complement
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate not representable, or undefined itype
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating count of results delivered with out_err=1

## Operation
- Stage 1: registers itype, tmpl, imm and computes err. Stage 2: registers packed out_inst and out_err.
- Field packing (non-immediate bits come from in_tmpl):
  - I: inst[31:20]=imm[11:0]. S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: inst[31:12]=imm[31:12]. J: inst[31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Shift form (tmpl opcode 0010011, funct3 001 or 101, itype I_TYPE): inst[24:20]=imm[4:0], inst[31:25]=tmpl[31:25] (funct7 preserved).
  - NULL_TYPE: out_inst=tmpl, err=0. Undefined codes (6,7): out_inst=tmpl, err=1.
- Representability (err=1 if violated):
  - I, S: imm[31:11] all equal. Shift form: imm[31:5]==0.
  - B: imm[31:12] all equal and imm[0]==0. J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
- On err, out_inst still carries the truncated field bits as above; consumer decides.
- err_cnt: increments by 1 on each output handshake with out_err=1; saturates at all-ones. err_clr wins over a simultaneous increment (result 0).

## Timing
- Reset (async assert, sync use after deassert): out_valid=0, out_inst=0, out_err=0, err_cnt=0, both stage valids 0; in_ready=1 while in reset released and pipeline empty.
- Latency: accepted in cycle N -> out_valid at cycle N+2 if out_ready held high.
- Throughput: one per cycle with out_ready=1.
- Flow control: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid to in_ready).
- out_valid stays high and out_inst/out_err stable until handshake; no drop, no duplicate, order preserved.
- Full: both stages valid and out_ready=0 -> in_ready=0. Simultaneous accept and deliver when full and out_ready=1 is allowed.
- Reset mid-stream discards in-flight requests; no partial output after release.

## Test plan
- I addi: tmpl 0x00010093, imm 0xFFFFFFFF, itype I_TYPE -> out_inst 0xFFF10093, out_err 0, out_valid exactly 2 cycles after accept.
- B beq: tmpl 0x00000063, imm 0xFFFFFFFE -> 0xFE000FE3, err 0; imm 0x00001000 -> err 1, err_cnt 1.
- Shift srai: tmpl 0x40015093, imm 3 -> 0x40315093, err 0; imm 32 -> err 1; U lui tmpl 0x000000B7, imm 0x12345000 -> 0x123450B7.
- J odd immediate 0x00000003 -> err 1; err_cnt counts; err_clr same cycle as an err delivery -> err_cnt 0; preload near saturation with CNT_W=2, deliver 5 errors -> err_cnt 3.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 with 3 distinct requests -> exactly 2 accepted, in_ready=0 thereafter, outputs in order with no duplicates after out_ready=1.
- Async rst_n pulse mid-stream (not clock-aligned) -> out_valid, out_inst, out_err, err_cnt 0 immediately; no stale output after release.
